// File: rtl/mult_acc_ctrl.sv
// Operand issue and product accumulation controller for the 4x4 pipelined multiplier.
// Beat tags ride a shift line matched to the multiplier latency; sums are released per frame.
module mult_acc_ctrl #(
  parameter int LAT   = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_fire;
  logic [LAT-1:0]   r_vld;
  logic [LAT-1:0]   r_last;
  logic             w_tag_vld;
  logic             w_tag_last;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W:0]   w_acc_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_ovf;

  // Returns {carry, value}; value clamps to all ones when the add overflows.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-7){1'b0}}, p};
    if (s[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  assign w_fire     = in_valid & in_ready;
  assign mul_a      = w_fire ? op_a : 4'd0;
  assign mul_b      = w_fire ? op_b : 4'd0;
  assign w_tag_vld  = r_vld[LAT-1];
  assign w_tag_last = r_last[LAT-1];
  assign w_acc_sum  = sat_add(r_acc, prod);
  assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // in_ready is decoded from state alone so it never depends on in_valid.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = in_last ? S_DRAIN : S_ACCUM;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_ACCUM;
        end
      end
      S_DRAIN: begin
        if (w_tag_vld && w_tag_last) begin
          w_next = S_HOLD;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= {LAT{1'b0}};
      r_last      <= {LAT{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= {ACC_W{1'b0}};
      r_out_cnt   <= {CNT_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else begin
      r_vld[0]  <= w_fire;
      r_last[0] <= w_fire & in_last;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
      end
      r_out_valid <= (w_next == S_HOLD);
      // The closing product is folded straight into the published result.
      if (r_state == S_DRAIN && w_tag_vld && w_tag_last) begin
        r_out_sum <= w_acc_sum[ACC_W-1:0];
        r_out_cnt <= w_cnt_nxt;
        r_out_ovf <= r_ovf | w_acc_sum[ACC_W];
        r_acc     <= {ACC_W{1'b0}};
        r_cnt     <= {CNT_W{1'b0}};
        r_ovf     <= 1'b0;
      end else if (w_tag_vld) begin
        r_acc <= w_acc_sum[ACC_W-1:0];
        r_cnt <= w_cnt_nxt;
        r_ovf <= r_ovf | w_acc_sum[ACC_W];
      end else begin
        r_acc <= r_acc;
        r_cnt <= r_cnt;
        r_ovf <= r_ovf;
      end
    end
  end

endmodule
